// File: rtl/axi_rab_pkg.sv
// Shared R-channel definitions for the RAB datapath: beat layout and field offsets.
package axi_rab_pkg;

  localparam int unsigned R_DATA_W = 32;
  localparam int unsigned R_ID_W   = 4;
  localparam int unsigned R_USER_W = 4;

  // Width-independent offsets of the low fields; data and user follow id.
  localparam int unsigned RESP_OFS = 0;
  localparam int unsigned LAST_OFS = 2;
  localparam int unsigned ID_OFS   = 3;

  typedef struct packed {
    logic [R_USER_W-1:0] user;
    logic [R_DATA_W-1:0] data;
    logic [R_ID_W-1:0]   id;
    logic                last;
    logic [1:0]          resp;
  } r_beat_t;

endpackage

// File: rtl/rab_sync_fifo.sv
// Flop-based synchronous FIFO with wrap-bit pointers and occupancy output.
module rab_sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    fill_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Payload storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata      = mem[rd_ptr[AW-1:0]];
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fill_level = CW'(wr_ptr - rd_ptr);

endmodule

// File: rtl/axi4_r_buffer_sf.sv
// AXI4 R-channel buffer: cut-through or store-and-forward release of bursts.
module axi4_r_buffer_sf
  import axi_rab_pkg::*;
#(
  parameter  int unsigned AXI_DATA_WIDTH = 32,
  parameter  int unsigned AXI_ID_WIDTH   = 4,
  parameter  int unsigned AXI_USER_WIDTH = 4,
  parameter  int unsigned DEPTH          = 4,
  parameter  int unsigned STORE_FWD      = 0,
  localparam int unsigned CW             = $clog2(DEPTH + 1)
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arstn,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
  input  logic [1:0]                m_axi4_rresp,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
  input  logic                      m_axi4_rlast,
  input  logic [AXI_USER_WIDTH-1:0] m_axi4_ruser,
  input  logic                      m_axi4_rvalid,
  output logic                      m_axi4_rready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi4_rid,
  output logic [1:0]                s_axi4_rresp,
  output logic [AXI_DATA_WIDTH-1:0] s_axi4_rdata,
  output logic                      s_axi4_rlast,
  output logic [AXI_USER_WIDTH-1:0] s_axi4_ruser,
  output logic                      s_axi4_rvalid,
  input  logic                      s_axi4_rready,
  output logic [CW-1:0]             fill_level_o,
  output logic [CW-1:0]             burst_cnt_o,
  output logic                      sf_bypass_o
);

  localparam int unsigned DATA_OFS = ID_OFS + AXI_ID_WIDTH;
  localparam int unsigned USER_OFS = DATA_OFS + AXI_DATA_WIDTH;
  localparam int unsigned BW       = USER_OFS + AXI_USER_WIDTH;
  localparam bit          SF       = (STORE_FWD != 0);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axi4_r_buffer_sf: DEPTH must be a power of two >= 2");
  end

  logic [BW-1:0] beat_in;
  logic [BW-1:0] beat_out;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [CW-1:0] burst_cnt;
  logic          sf_cond;
  logic          sf_hold;

  assign beat_in = {m_axi4_ruser, m_axi4_rdata, m_axi4_rid, m_axi4_rlast, m_axi4_rresp};

  rab_sync_fifo #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (axi4_aclk),
    .rst_n      (axi4_arstn),
    .push       (push),
    .pop        (pop),
    .wdata      (beat_in),
    .rdata      (beat_out),
    .full       (full),
    .empty      (empty),
    .fill_level (fill_level_o)
  );

  // Handshakes and release gating; ready depends only on occupancy.
  always_comb begin
    m_axi4_rready = !full;
    s_axi4_rvalid = !empty && (!SF || (burst_cnt != '0) || full);
    push          = m_axi4_rvalid && m_axi4_rready;
    pop           = s_axi4_rvalid && s_axi4_rready;
    sf_cond       = SF && full && (burst_cnt == '0) && s_axi4_rvalid;
  end

  assign s_axi4_rresp = beat_out[RESP_OFS +: 2];
  assign s_axi4_rlast = beat_out[LAST_OFS];
  assign s_axi4_rid   = beat_out[ID_OFS +: AXI_ID_WIDTH];
  assign s_axi4_rdata = beat_out[DATA_OFS +: AXI_DATA_WIDTH];
  assign s_axi4_ruser = beat_out[USER_OFS +: AXI_USER_WIDTH];
  assign burst_cnt_o  = burst_cnt;

  // Count of complete bursts (buffered RLAST beats).
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      burst_cnt <= '0;
    end else begin
      unique case ({push && m_axi4_rlast, pop && s_axi4_rlast})
        2'b10:   burst_cnt <= burst_cnt + CW'(1);
        2'b01:   burst_cnt <= burst_cnt - CW'(1);
        default: burst_cnt <= burst_cnt;
      endcase
    end
  end

  // One pulse each time the full-rule override of store-and-forward begins.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      sf_hold     <= 1'b0;
      sf_bypass_o <= 1'b0;
    end else begin
      sf_hold     <= sf_cond;
      sf_bypass_o <= sf_cond && !sf_hold;
    end
  end

endmodule

// File: tb/tb_axi4_r_buffer_sf.sv
// Bench for axi4_r_buffer_sf: tables, directed corner sequences, randomized model check.
module tb_axi4_r_buffer_sf;

  typedef struct packed {
    logic [3:0]  user;
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
    logic [1:0]  resp;
  } beat_t;

  typedef struct {
    logic v; logic [31:0] d; logic l; logic r;
    logic sv; logic mr; int fill; int burst; logic [31:0] ed; logic el;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst_n;
  beat_t in_b;
  logic  m_valid;
  logic  s_ready;

  logic [3:0]  sid   [3];
  logic [1:0]  sresp [3];
  logic [31:0] sdata [3];
  logic        slast [3];
  logic [3:0]  suser [3];
  logic        svalid[3];
  logic        mready[3];
  logic        byp   [3];
  logic [2:0]  fill_c4, burst_c4, fill_s4, burst_s4;
  logic [3:0]  fill_s8, burst_s8;

  axi4_r_buffer_sf #(.DEPTH(4), .STORE_FWD(0)) u_ct4 (
    .axi4_aclk(clk), .axi4_arstn(rst_n),
    .m_axi4_rid(in_b.id), .m_axi4_rresp(in_b.resp), .m_axi4_rdata(in_b.data),
    .m_axi4_rlast(in_b.last), .m_axi4_ruser(in_b.user), .m_axi4_rvalid(m_valid),
    .m_axi4_rready(mready[0]),
    .s_axi4_rid(sid[0]), .s_axi4_rresp(sresp[0]), .s_axi4_rdata(sdata[0]),
    .s_axi4_rlast(slast[0]), .s_axi4_ruser(suser[0]), .s_axi4_rvalid(svalid[0]),
    .s_axi4_rready(s_ready),
    .fill_level_o(fill_c4), .burst_cnt_o(burst_c4), .sf_bypass_o(byp[0]));

  axi4_r_buffer_sf #(.DEPTH(8), .STORE_FWD(1)) u_sf8 (
    .axi4_aclk(clk), .axi4_arstn(rst_n),
    .m_axi4_rid(in_b.id), .m_axi4_rresp(in_b.resp), .m_axi4_rdata(in_b.data),
    .m_axi4_rlast(in_b.last), .m_axi4_ruser(in_b.user), .m_axi4_rvalid(m_valid),
    .m_axi4_rready(mready[1]),
    .s_axi4_rid(sid[1]), .s_axi4_rresp(sresp[1]), .s_axi4_rdata(sdata[1]),
    .s_axi4_rlast(slast[1]), .s_axi4_ruser(suser[1]), .s_axi4_rvalid(svalid[1]),
    .s_axi4_rready(s_ready),
    .fill_level_o(fill_s8), .burst_cnt_o(burst_s8), .sf_bypass_o(byp[1]));

  axi4_r_buffer_sf #(.DEPTH(4), .STORE_FWD(1)) u_sf4 (
    .axi4_aclk(clk), .axi4_arstn(rst_n),
    .m_axi4_rid(in_b.id), .m_axi4_rresp(in_b.resp), .m_axi4_rdata(in_b.data),
    .m_axi4_rlast(in_b.last), .m_axi4_ruser(in_b.user), .m_axi4_rvalid(m_valid),
    .m_axi4_rready(mready[2]),
    .s_axi4_rid(sid[2]), .s_axi4_rresp(sresp[2]), .s_axi4_rdata(sdata[2]),
    .s_axi4_rlast(slast[2]), .s_axi4_ruser(suser[2]), .s_axi4_rvalid(svalid[2]),
    .s_axi4_rready(s_ready),
    .fill_level_o(fill_s4), .burst_cnt_o(burst_s4), .sf_bypass_o(byp[2]));

  // Observed outputs of the instance under test.
  int         sel = 0;
  beat_t      o_b;
  logic       o_sv, o_mr, o_byp;
  logic [3:0] o_fill, o_burst;

  always_comb begin
    o_b.user = suser[sel];
    o_b.data = sdata[sel];
    o_b.id   = sid[sel];
    o_b.last = slast[sel];
    o_b.resp = sresp[sel];
    o_sv     = svalid[sel];
    o_mr     = mready[sel];
    o_byp    = byp[sel];
    case (sel)
      1:       begin o_fill = fill_s8;         o_burst = burst_s8;         end
      2:       begin o_fill = {1'b0, fill_s4}; o_burst = {1'b0, burst_s4}; end
      default: begin o_fill = {1'b0, fill_c4}; o_burst = {1'b0, burst_c4}; end
    endcase
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.id   = d[3:0];
    b.user = d[7:4];
    b.resp = d[1:0];
    b.last = l;
    return b;
  endfunction

  function automatic vec_t mkv(input logic v, input logic [31:0] d, input logic l, input logic r,
                               input logic sv, input logic mr, input int fill, input int burst,
                               input logic [31:0] ed, input logic el);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r; t.sv = sv; t.mr = mr;
    t.fill = fill; t.burst = burst; t.ed = ed; t.el = el;
    return t;
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic r);
    m_valid = v;
    in_b    = mk(d, l);
    s_ready = r;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int s);
    sel = s;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic expect_st(input string name, input logic sv, input logic mr,
                           input int fill, input int burst);
    #1;
    chk({name, "_rvalid"}, 64'(o_sv), 64'(sv));
    chk({name, "_mready"}, 64'(o_mr), 64'(mr));
    chk({name, "_fill"},   64'(o_fill), 64'(fill));
    chk({name, "_burst"},  64'(o_burst), 64'(burst));
  endtask

  task automatic expect_beat(input string name, input logic [31:0] d, input logic l);
    chk({name, "_beat"}, 64'(o_b), 64'(mk(d, l)));
  endtask

  vec_t  tbl[17];
  beat_t q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Cut-through, DEPTH=4: streaming, then backpressure with a fifth beat.
    tbl[0]  = mkv(1, 32'hA0, 0, 1,  0, 1, 0, 0, 32'h00, 0);
    tbl[1]  = mkv(1, 32'hA1, 0, 1,  1, 1, 1, 0, 32'hA0, 0);
    tbl[2]  = mkv(1, 32'hA2, 0, 1,  1, 1, 1, 0, 32'hA1, 0);
    tbl[3]  = mkv(1, 32'hA3, 1, 1,  1, 1, 1, 0, 32'hA2, 0);
    tbl[4]  = mkv(0, 32'h00, 0, 1,  1, 1, 1, 1, 32'hA3, 1);
    tbl[5]  = mkv(0, 32'h00, 0, 1,  0, 1, 0, 0, 32'h00, 0);
    tbl[6]  = mkv(1, 32'hB0, 0, 0,  0, 1, 0, 0, 32'h00, 0);
    tbl[7]  = mkv(1, 32'hB1, 0, 0,  1, 1, 1, 0, 32'hB0, 0);
    tbl[8]  = mkv(1, 32'hB2, 0, 0,  1, 1, 2, 0, 32'hB0, 0);
    tbl[9]  = mkv(1, 32'hB3, 0, 0,  1, 1, 3, 0, 32'hB0, 0);
    tbl[10] = mkv(1, 32'hB4, 1, 0,  1, 0, 4, 0, 32'hB0, 0);
    tbl[11] = mkv(1, 32'hB4, 1, 1,  1, 0, 4, 0, 32'hB0, 0);
    tbl[12] = mkv(1, 32'hB4, 1, 1,  1, 1, 3, 0, 32'hB1, 0);
    tbl[13] = mkv(0, 32'h00, 0, 1,  1, 1, 3, 1, 32'hB2, 0);
    tbl[14] = mkv(0, 32'h00, 0, 1,  1, 1, 2, 1, 32'hB3, 0);
    tbl[15] = mkv(0, 32'h00, 0, 1,  1, 1, 1, 1, 32'hB4, 1);
    tbl[16] = mkv(0, 32'h00, 0, 1,  0, 1, 0, 0, 32'h00, 0);

    do_reset(0);
    expect_st("reset_ct4", 0, 1, 0, 0);
    chk("reset_ct4_bypass", 64'(o_byp), 64'(0));
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
      expect_st($sformatf("tbl%0d", i), tbl[i].sv, tbl[i].mr, tbl[i].fill, tbl[i].burst);
      if (tbl[i].sv) expect_beat($sformatf("tbl%0d", i), tbl[i].ed, tbl[i].el);
      cycle();
    end

    // Store-and-forward, DEPTH=8: 3-beat burst with a 5-cycle gap before RLAST.
    do_reset(1);
    drive(1, 32'hC0, 0, 1); expect_st("sf8_c0", 0, 1, 0, 0); cycle();
    drive(1, 32'hC1, 0, 1); expect_st("sf8_c1", 0, 1, 1, 0); cycle();
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'h0, 0, 1); expect_st("sf8_gap", 0, 1, 2, 0); cycle();
    end
    drive(1, 32'hC2, 1, 1); expect_st("sf8_c2", 0, 1, 2, 0); cycle();
    drive(0, 32'h0, 0, 1);
    expect_st("sf8_out0", 1, 1, 3, 1); expect_beat("sf8_out0", 32'hC0, 0); cycle();
    expect_st("sf8_out1", 1, 1, 2, 1); expect_beat("sf8_out1", 32'hC1, 0); cycle();
    expect_st("sf8_out2", 1, 1, 1, 1); expect_beat("sf8_out2", 32'hC2, 1); cycle();
    expect_st("sf8_done", 0, 1, 0, 0);

    // Store-and-forward, DEPTH=4: 6-beat burst must escape through the full rule.
    begin
      int idx, got, pulses;
      bit saw_full;
      idx = 0; got = 0; pulses = 0; saw_full = 0;
      do_reset(2);
      for (int c = 0; c < 60 && got < 6; c++) begin
        drive(idx < 6, 32'hD0 + 32'(idx), idx == 5, 1);
        #1;
        if (o_byp) pulses++;
        if (o_sv && o_fill == 4'd4 && o_burst == 4'd0) saw_full = 1;
        if (o_sv) begin
          expect_beat($sformatf("sf4_out%0d", got), 32'hD0 + 32'(got), got == 5);
          got++;
        end
        if (m_valid && o_mr) idx++;
        cycle();
      end
      drive(0, 32'h0, 0, 1);
      for (int c = 0; c < 4; c++) begin
        #1;
        if (o_byp) pulses++;
        cycle();
      end
      chk("sf4_beats_received", 64'(got), 64'(6));
      chk("sf4_full_seen", 64'(saw_full), 64'(1));
      chk("sf4_bypass_pulses", 64'(pulses), 64'(2));
      expect_st("sf4_done", 0, 1, 0, 0);
    end

    // Simultaneous RLAST push and RLAST pop with two bursts queued.
    do_reset(0);
    drive(1, 32'hE0, 1, 0); expect_st("simul_e0", 0, 1, 0, 0); cycle();
    drive(1, 32'hE1, 1, 0); expect_st("simul_e1", 1, 1, 1, 1); cycle();
    drive(1, 32'hE2, 1, 1); expect_st("simul_pre", 1, 1, 2, 2);
    expect_beat("simul_pre", 32'hE0, 1); cycle();
    drive(0, 32'h0, 0, 0); expect_st("simul_post", 1, 1, 2, 2);
    expect_beat("simul_post", 32'hE1, 1);
    cycle();

    // Reset asserted mid-burst with three beats stored.
    do_reset(0);
    drive(1, 32'hF0, 0, 0); cycle();
    drive(1, 32'hF1, 0, 0); cycle();
    drive(1, 32'hF2, 0, 0); cycle();
    drive(0, 32'h0, 0, 0);
    expect_st("midrst_pre", 1, 1, 3, 0);
    rst_n = 1'b0;
    expect_st("midrst_async", 0, 1, 0, 0);
    chk("midrst_bypass", 64'(o_byp), 64'(0));
    cycle();
    rst_n = 1'b1;
    cycle();
    drive(1, 32'h60, 1, 1); expect_st("midrst_g0", 0, 1, 0, 0); cycle();
    drive(0, 32'h0, 0, 1); expect_st("midrst_first", 1, 1, 1, 1);
    expect_beat("midrst_first", 32'h60, 1);
    cycle();

    // Randomized traffic against a queue-based reference, all three configurations.
    for (int s = 0; s < 3; s++) begin
      int    depth;
      bit    sf, cond_last, exp_byp;
      depth = (s == 1) ? 8 : 4;
      sf    = (s != 0);
      cond_last = 0;
      exp_byp   = 0;
      q.delete();
      do_reset(s);
      for (int c = 0; c < 400; c++) begin
        beat_t b;
        bit v, r, exp_mr, exp_sv, cond;
        int sz, nb;
        b.data = $urandom;
        b.id   = 4'($urandom_range(0, 15));
        b.user = 4'($urandom_range(0, 15));
        b.resp = 2'($urandom_range(0, 3));
        b.last = ($urandom_range(0, 2) == 0);
        v = ($urandom_range(0, 3) != 0);
        r = (c < 200) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) != 0);
        m_valid = v;
        in_b    = b;
        s_ready = r;
        #1;
        sz = q.size();
        nb = 0;
        foreach (q[k]) if (q[k].last) nb++;
        exp_mr = (sz < depth);
        exp_sv = (sz > 0) && (!sf || nb > 0 || sz == depth);
        chk("rnd_mready", 64'(o_mr), 64'(exp_mr));
        chk("rnd_rvalid", 64'(o_sv), 64'(exp_sv));
        chk("rnd_fill",   64'(o_fill), 64'(sz));
        chk("rnd_burst",  64'(o_burst), 64'(nb));
        chk("rnd_bypass", 64'(o_byp), 64'(exp_byp));
        if (exp_sv) chk("rnd_beat", 64'(o_b), 64'(q[0]));
        cond = sf && (sz == depth) && (nb == 0);
        cycle();
        exp_byp   = cond && !cond_last;
        cond_last = cond;
        if (exp_sv && r) void'(q.pop_front());
        if (v && exp_mr) q.push_back(b);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_r_buffer_sf.md
# axi4_r_buffer_sf

Parametrised AXI4 read-data (R) channel buffer for the RAB datapath, successor to the fixed two-entry R-channel slice. It holds DEPTH beats in a flop FIFO and runs in either cut-through mode or store-and-forward mode. Store-and-forward releases a burst to the master only once its RLAST beat is buffered. It sits between the slave port of the RAB (m_* side, from the downstream slave) and the master-facing port (s_* side, toward the requesting master), and exports fill and burst counts for monitoring.

## Interface
- AXI_DATA_WIDTH, 32: RDATA width.
- AXI_ID_WIDTH, 4: RID width.
- AXI_USER_WIDTH, 4: RUSER width.
- DEPTH, 4: number of beat entries; must be a power of two ≥ 2 (elaboration-time assertion).
- STORE_FWD, 0: 0 = cut-through, 1 = store-and-forward.

Ports:
- axi4_aclk  in  1  clock; one clock domain.
- axi4_arstn  in  1  reset, asynchronous, active-low.
- m_axi4_rid / rresp / rdata / rlast / ruser  in  ID/2/DATA/1/USER  incoming beat.
- m_axi4_rvalid  in  1  incoming beat valid.
- m_axi4_rready  out  1  buffer can accept a beat.
- s_axi4_rid / rresp / rdata / rlast / ruser  out  ID/2/DATA/1/USER  outgoing beat.
- s_axi4_rvalid  out  1  outgoing beat valid.
- s_axi4_rready  in  1  master accepts a beat.
- fill_level_o  out  $clog2(DEPTH+1)  beats currently stored.
- burst_cnt_o  out  $clog2(DEPTH+1)  complete bursts (stored RLAST beats) in the buffer.
- sf_bypass_o  out  1  1-cycle pulse when a store-and-forward stall is broken by the full rule.

## Operation
- Each beat is packed as {user, data, id, last, resp}, with resp at the LSBs. It is written into entry wr_ptr and read from entry rd_ptr.
- Pointers are log2(DEPTH)+1 bits. They wrap naturally.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and the LSBs are equal.
- Push condition: m_axi4_rvalid && m_axi4_rready. Pop condition: s_axi4_rvalid && s_axi4_rready.
- m_axi4_rready = !full. It does not depend on s_axi4_rready in the same cycle, so there is no combinational ready path. A full buffer refuses a push even if a pop occurs that cycle.
- Cut-through mode: s_axi4_rvalid = !empty.
- Store-and-forward mode: s_axi4_rvalid = !empty && (burst_cnt != 0 || full).
  - The full term breaks deadlock for bursts longer than DEPTH.
  - sf_bypass_o = full && burst_cnt == 0 && s_axi4_rvalid, registered as a pulse per entry into that condition.
- burst_cnt counts as follows:
  - +1 on a push with rlast=1.
  - −1 on a pop with rlast=1.
  - Unchanged when both happen in the same cycle.
  - Saturation is impossible, since burst_cnt ≤ fill_level.
- fill_level updates as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- s_* payload is driven combinationally from entry rd_ptr. While s_axi4_rvalid=1 and the beat is not popped, the payload is held stable (AXI rule).
- Payload is not reset. Contents of unread entries are don't-care.

## Timing
- Reset (async assert, sync-free deassert on the flops) sets:
  - wr_ptr = rd_ptr = 0
  - burst_cnt = 0, fill_level = 0
  - s_axi4_rvalid = 0, m_axi4_rready = 1, sf_bypass_o = 0
- Reset mid-burst discards all stored beats. No partial beat survives.
- Latency, cut-through: a beat pushed at edge N is visible on s_* with rvalid=1 after edge N (one cycle). There is no same-cycle bypass.
- Latency, store-and-forward: the first beat of a burst becomes valid one cycle after its RLAST beat is pushed.
- Throughput: one beat per cycle sustained in both modes when DEPTH ≥ 2 and the master is always ready. With DEPTH=2, full blocks only while occupancy is 2.
- Empty + push + pop in the same cycle: the pop is impossible (rvalid=0), so only the push occurs.

## Structure
- Shared package axi_rab_pkg holds:
  - r_beat_t packed struct {user, data, id, last, resp}, parametrised through localparams matching the parameter defaults.
  - Field-offset constants.
- Sub-module rab_sync_fifo (WIDTH, DEPTH) contains the storage, pointers, full, empty and fill_level.
- The top adds packing, burst_cnt, the store-and-forward gating, and sf_bypass_o.

## Test plan
- Cut-through, DEPTH=4: push beats 0xA0..0xA3 with master ready=1 → each appears one cycle after push, in order, with rlast, id and user intact.
- Backpressure: s_axi4_rready=0, push 5 beats → m_axi4_rready drops after the 4th, fill_level_o=4. Release → beats drain in order; the 5th is accepted on the first cycle after full clears.
- Store-and-forward, DEPTH=8: push a 3-beat burst with an RLAST gap of 5 idle cycles → s_axi4_rvalid stays 0 until one cycle after RLAST, then 3 back-to-back beats. burst_cnt_o goes 0→1→0.
- Store-and-forward, DEPTH=4: 6-beat burst → full at 4 beats with burst_cnt=0, sf_bypass_o pulses, and all 6 beats arrive in order with no deadlock.
- Simultaneous RLAST push and RLAST pop with two bursts queued → burst_cnt_o unchanged and fill_level_o unchanged.
- axi4_arstn asserted mid-burst with fill_level=3 → outputs immediately take reset values (rvalid=0, rready=1, counts 0). The next push after release is the first beat out.
